// File: rtl/jsilicon_uart_cmd_rx.sv
// Purpose  : 8N1 UART receiver + 3-byte command framer {SYNC, a:b, opcode} feeding the core.
// Latency  : cmd_valid rises 1 clk after the mid-bit stop sample of the opcode byte.
// Backpres.: single holding register; a frame completing while it is full is dropped (overrun).
//
// Ports
//   clk         system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   ena         1 = run; 0 = receiver/framer held idle, holding register kept
//   rx          UART serial input (idle high, asynchronous to clk)
//   cmd_ready   core accepts the command when cmd_valid && cmd_ready
//   cmd_valid   holding register holds an unconsumed command
//   cmd_a       operand A  (frame byte 1 [7:4])
//   cmd_b       operand B  (frame byte 1 [3:0])
//   cmd_opcode  opcode     (frame byte 2 [2:0])
//   frame_err   1-cycle pulse: bad stop bit, or opcode byte [7:3] != 0
//   overrun     1-cycle pulse: complete frame dropped, holding register full
module jsilicon_uart_cmd_rx #(
  parameter int         CLKS_PER_BIT = 87,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [3:0] cmd_a,
  output logic [3:0] cmd_b,
  output logic [2:0] cmd_opcode,
  output logic       frame_err,
  output logic       overrun
);

  // Bit-period counter sizing
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // Receiver states
  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  // Framer states
  localparam logic [1:0] FR_HUNT     = 2'd0;
  localparam logic [1:0] FR_GOT_SYNC = 2'd1;
  localparam logic [1:0] FR_GOT_OPS  = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             rx_meta_q;
  logic             rxs_q;
  logic [2:0]       rx_state_q,  rx_state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic [1:0]       fr_state_q,  fr_state_d;
  logic [7:0]       ops_q,       ops_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [3:0]       cmd_a_q,     cmd_a_d;
  logic [3:0]       cmd_b_q,     cmd_b_d;
  logic [2:0]       cmd_op_q,    cmd_op_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q,   overrun_d;

  // Internal single-cycle strobes
  logic byte_done;       // good stop bit; shift_q holds the received byte
  logic stop_err;        // stop bit sampled low
  logic fmt_err;         // opcode byte has non-zero reserved bits
  logic frame_complete;  // third byte of a good frame received
  logic cmd_accept;
  logic cmd_load;

  // ---------------------------------------------------------------------------
  // Receiver: START waits half a bit and re-checks so that every later sample
  // lands mid-bit after a full CLKS_PER_BIT interval.
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_done  = 1'b0;
    stop_err   = 1'b0;

    if (!ena) begin
      rx_state_d = RX_IDLE;
      cnt_d      = '0;
      bit_idx_d  = '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          cnt_d     = '0;
          bit_idx_d = '0;
          if (!rxs_q) begin
            rx_state_d = RX_START;
          end
        end

        RX_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            // Line back high at mid start bit: treat as a glitch
            rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        RX_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            shift_d   = {rxs_q, shift_q[7:1]};  // LSB first
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              rx_state_d = RX_STOP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        RX_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rxs_q) begin
              byte_done  = 1'b1;
              rx_state_d = RX_IDLE;
            end else begin
              stop_err   = 1'b1;
              // A held-low line must not be read as a new start bit
              rx_state_d = RX_WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        RX_WAIT_HIGH: begin
          cnt_d = '0;
          if (rxs_q) begin
            rx_state_d = RX_IDLE;
          end
        end

        default: begin
          rx_state_d = RX_IDLE;
          cnt_d      = '0;
          bit_idx_d  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Framer: SYNC, operand byte, opcode byte. Any error returns to HUNT.
  // ---------------------------------------------------------------------------
  always_comb begin
    fr_state_d     = fr_state_q;
    ops_d          = ops_q;
    fmt_err        = 1'b0;
    frame_complete = 1'b0;

    if (!ena || stop_err) begin
      fr_state_d = FR_HUNT;
    end else if (byte_done) begin
      case (fr_state_q)
        FR_HUNT: begin
          if (shift_q == SYNC_BYTE) begin
            fr_state_d = FR_GOT_SYNC;
          end
        end

        FR_GOT_SYNC: begin
          ops_d      = shift_q;
          fr_state_d = FR_GOT_OPS;
        end

        FR_GOT_OPS: begin
          fr_state_d = FR_HUNT;
          if (shift_q[7:3] != 5'd0) begin
            fmt_err = 1'b1;
          end else begin
            frame_complete = 1'b1;
          end
        end

        default: begin
          fr_state_d = FR_HUNT;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register: a slot freed by a same-cycle handshake can be refilled.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_accept = cmd_valid_q && cmd_ready;
    cmd_load   = frame_complete && (!cmd_valid_q || cmd_ready);

    cmd_valid_d = cmd_valid_q;
    cmd_a_d     = cmd_a_q;
    cmd_b_d     = cmd_b_q;
    cmd_op_d    = cmd_op_q;

    if (cmd_load) begin
      cmd_valid_d = 1'b1;
      cmd_a_d     = ops_q[7:4];
      cmd_b_d     = ops_q[3:0];
      cmd_op_d    = shift_q[2:0];
    end else if (cmd_accept) begin
      cmd_valid_d = 1'b0;
    end

    frame_err_d = stop_err || fmt_err;
    overrun_d   = frame_complete && !cmd_load;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchronizer resets to the idle-line level so release is not a start bit
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      fr_state_q  <= FR_HUNT;
      ops_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_a_q     <= '0;
      cmd_b_q     <= '0;
      cmd_op_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rxs_q       <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      fr_state_q  <= fr_state_d;
      ops_q       <= ops_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_a_q     <= cmd_a_d;
      cmd_b_q     <= cmd_b_d;
      cmd_op_q    <= cmd_op_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_a      = cmd_a_q;
  assign cmd_b      = cmd_b_q;
  assign cmd_opcode = cmd_op_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
